// File: rtl/vec_load_writeback_if.sv
// vec_load_writeback_if: command, load-data and bank-write signals of the vector load writeback block
interface vec_load_writeback_if #(parameter int BITS = 32);
  logic            CMD_VALID;
  logic            CMD_READY;
  logic [3:0]      CMD_REG;
  logic [4:0]      CMD_COUNT;
  logic            DATA_VALID;
  logic            DATA_READY;
  logic [BITS-1:0] DATA_IN;
  logic            REG_WE;
  logic [3:0]      REG_A;
  logic [BITS-1:0] REG_WD;
  logic [15:0]     PENDING;
  logic            BUSY;
  logic            DONE;
  modport master (
    output CMD_VALID, CMD_REG, CMD_COUNT, DATA_VALID, DATA_IN,
    input  CMD_READY, DATA_READY, REG_WE, REG_A, REG_WD, PENDING, BUSY, DONE
  );
  modport slave (
    input  CMD_VALID, CMD_REG, CMD_COUNT, DATA_VALID, DATA_IN,
    output CMD_READY, DATA_READY, REG_WE, REG_A, REG_WD, PENDING, BUSY, DONE
  );
endinterface

// File: rtl/vec_load_writeback.sv
// vec_load_writeback: streams a multi-word load into consecutive bank registers via one write port
module vec_load_writeback #(
  parameter int BITS       = 32,
  parameter int PROTECT_R0 = 1
) (
  input logic                CLK,
  input logic                RST,
  vec_load_writeback_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, FIN} state_t;
  state_t      state;
  logic [3:0]  ptr;
  logic [4:0]  rem;
  logic [4:0]  cnt;
  logic [15:0] mask;
  logic        wrote;
  assign cnt = bus.CMD_COUNT > 5'd16 ? 5'd16 : bus.CMD_COUNT;
  for (genvar i = 0; i < 16; i++) begin : g_mask
    assign mask[i] = {1'b0, 4'(i) - bus.CMD_REG} < cnt;
  end
  assign bus.CMD_READY  = state == IDLE;
  assign bus.DATA_READY = state == XFER;
  assign bus.BUSY       = state != IDLE;
  // sequencer: latch command, emit one registered bank write per accepted beat, retire pending bits on capture
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state       <= IDLE;
      ptr         <= 4'd0;
      rem         <= 5'd0;
      wrote       <= 1'b0;
      bus.REG_WE  <= 1'b0;
      bus.REG_A   <= 4'd0;
      bus.REG_WD  <= BITS'(0);
      bus.PENDING <= 16'd0;
      bus.DONE    <= 1'b0;
    end else begin
      bus.REG_WE <= 1'b0;
      bus.DONE   <= 1'b0;
      wrote      <= 1'b0;
      if (wrote) bus.PENDING[bus.REG_A] <= 1'b0;
      case (state)
        IDLE:
          if (bus.CMD_VALID) begin
            ptr         <= bus.CMD_REG;
            rem         <= cnt;
            bus.PENDING <= mask;
            state       <= cnt == 5'd0 ? FIN : XFER;
            bus.DONE    <= cnt == 5'd0;
          end
        XFER:
          if (bus.DATA_VALID) begin
            wrote      <= 1'b1;
            bus.REG_WE <= !(PROTECT_R0 != 0 && ptr == 4'd0);
            bus.REG_A  <= ptr;
            bus.REG_WD <= bus.DATA_IN;
            ptr        <= ptr + 4'd1;
            rem        <= rem - 5'd1;
            if (rem == 5'd1) begin
              state    <= FIN;
              bus.DONE <= 1'b1;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_vec_load_writeback.sv
// tb_vec_load_writeback: directed table-driven and sequence checks of the vector load writeback block
module tb_vec_load_writeback;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  vec_load_writeback_if #(.BITS(32)) bus ();
  vec_load_writeback #(.BITS(32), .PROTECT_R0(1)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  typedef struct {
    logic        cv;
    logic [3:0]  creg;
    logic [4:0]  ccnt;
    logic        dv;
    logic [31:0] din;
    logic        ewe;
    logic [3:0]  ea;
    logic [31:0] ewd;
    logic [15:0] epend;
    logic        edone;
    logic        ecr;
  } vec_t;
  vec_t v[$];
  logic [31:0] bank [16];
  int checks = 0;
  int errors = 0;
  always @(posedge CLK)
    if (RST) for (int i = 0; i < 16; i++) bank[i] <= 32'd0;
    else if (bus.REG_WE) bank[bus.REG_A] <= bus.REG_WD;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic cv, input logic [3:0] creg, input logic [4:0] ccnt,
                              input logic dv, input logic [31:0] din, input logic ewe,
                              input logic [3:0] ea, input logic [31:0] ewd, input logic [15:0] epend,
                              input logic edone, input logic ecr);
    vec_t r;
    r.cv = cv; r.creg = creg; r.ccnt = ccnt; r.dv = dv; r.din = din; r.ewe = ewe;
    r.ea = ea; r.ewd = ewd; r.epend = epend; r.edone = edone; r.ecr = ecr;
    return r;
  endfunction
  initial begin
    int cyc, nwr, dup, trio, ndone;
    logic [15:0] seen;
    bus.CMD_VALID = 0; bus.CMD_REG = 0; bus.CMD_COUNT = 0; bus.DATA_VALID = 0; bus.DATA_IN = 0;
    // R2 x3, back to back
    v.push_back(mk(1, 2, 3, 0, 0,     0, 0, 0,     16'h001C, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'hA,   1, 2, 'hA,   16'h001C, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'hB,   1, 3, 'hB,   16'h0018, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'hC,   1, 4, 'hC,   16'h0010, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h0000, 0, 1));
    // R14 x4, wraps through protected R0
    v.push_back(mk(1, 14, 4, 0, 0,    0, 0, 0,     16'hC003, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h1,   1, 14, 'h1,  16'hC003, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h2,   1, 15, 'h2,  16'h8003, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h3,   0, 0, 0,     16'h0003, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h4,   1, 1, 'h4,   16'h0002, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h0000, 0, 1));
    // R5 x3 with a two-cycle data gap
    v.push_back(mk(1, 5, 3, 0, 0,     0, 0, 0,     16'h00E0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h11,  1, 5, 'h11,  16'h00E0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h00C0, 0, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h00C0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h22,  1, 6, 'h22,  16'h00C0, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h33,  1, 7, 'h33,  16'h0080, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h0000, 0, 1));
    // zero-length command
    v.push_back(mk(1, 3, 0, 0, 0,     0, 0, 0,     16'h0000, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h0000, 0, 1));
    // command held during transfer, data held in idle
    v.push_back(mk(1, 8, 1, 1, 'h55,  0, 0, 0,     16'h0100, 0, 0));
    v.push_back(mk(1, 9, 2, 1, 'h66,  1, 8, 'h66,  16'h0100, 1, 0));
    v.push_back(mk(1, 9, 2, 1, 'h77,  0, 0, 0,     16'h0000, 0, 1));
    v.push_back(mk(1, 9, 2, 1, 'h88,  0, 0, 0,     16'h0600, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'h99,  1, 9, 'h99,  16'h0600, 0, 0));
    v.push_back(mk(0, 0, 0, 1, 'hAA,  1, 10, 'hAA, 16'h0400, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 'hBB,  0, 0, 0,     16'h0000, 0, 1));
    v.push_back(mk(0, 0, 0, 0, 0,     0, 0, 0,     16'h0000, 0, 1));
    repeat (2) @(posedge CLK);
    #1;
    chk("rst we", bus.REG_WE, 0);
    chk("rst pend", bus.PENDING, 0);
    chk("rst done", bus.DONE, 0);
    chk("rst busy", bus.BUSY, 0);
    chk("rst cready", bus.CMD_READY, 1);
    chk("rst dready", bus.DATA_READY, 0);
    RST = 0;
    foreach (v[k]) begin
      bus.CMD_VALID = v[k].cv; bus.CMD_REG = v[k].creg; bus.CMD_COUNT = v[k].ccnt;
      bus.DATA_VALID = v[k].dv; bus.DATA_IN = v[k].din;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d we", k), bus.REG_WE, v[k].ewe);
      if (v[k].ewe) begin
        chk($sformatf("v%0d addr", k), bus.REG_A, v[k].ea);
        chk($sformatf("v%0d wdata", k), bus.REG_WD, v[k].ewd);
      end
      chk($sformatf("v%0d pend", k), bus.PENDING, v[k].epend);
      chk($sformatf("v%0d done", k), bus.DONE, v[k].edone);
      chk($sformatf("v%0d cready", k), bus.CMD_READY, v[k].ecr);
    end
    bus.CMD_VALID = 0; bus.DATA_VALID = 0;
    chk("bank r2", bank[2], 32'hA);
    chk("bank r3", bank[3], 32'hB);
    chk("bank r4", bank[4], 32'hC);
    chk("bank r14", bank[14], 32'h1);
    chk("bank r15", bank[15], 32'h2);
    chk("bank r0", bank[0], 32'h0);
    chk("bank r1", bank[1], 32'h4);
    // reset after 2 of 5 beats
    bus.CMD_VALID = 1; bus.CMD_REG = 3; bus.CMD_COUNT = 5;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 0; bus.DATA_VALID = 1; bus.DATA_IN = 32'h111;
    @(posedge CLK);
    #1;
    chk("mid we1", bus.REG_WE, 1);
    chk("mid a1", bus.REG_A, 3);
    bus.DATA_IN = 32'h222;
    @(posedge CLK);
    #1;
    chk("mid a2", bus.REG_A, 4);
    chk("mid pend", bus.PENDING, 16'h00F0);
    #2 RST = 1;
    #1;
    chk("arst we", bus.REG_WE, 0);
    chk("arst pend", bus.PENDING, 0);
    chk("arst busy", bus.BUSY, 0);
    chk("arst cready", bus.CMD_READY, 1);
    chk("arst dready", bus.DATA_READY, 0);
    chk("arst wd", bus.REG_WD, 0);
    @(posedge CLK);
    #1;
    chk("arst hold we", bus.REG_WE, 0);
    bus.DATA_VALID = 0;
    #2 RST = 0;
    // clamped count 20 from R6, data held valid
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 1; bus.CMD_REG = 6; bus.CMD_COUNT = 20;
    @(posedge CLK);
    #1;
    bus.CMD_VALID = 0;
    chk("clamp pend", bus.PENDING, 16'hFFFF);
    bus.DATA_VALID = 1; bus.DATA_IN = 32'h5A5A;
    cyc = 0; nwr = 0; dup = 0; trio = 0; ndone = 0; seen = 0;
    for (int i = 0; i < 40 && !bus.CMD_READY; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (bus.REG_WE) begin
        nwr++;
        if (seen[bus.REG_A]) dup++;
        seen[bus.REG_A] = 1'b1;
      end
      if (bus.DONE) ndone++;
      if (bus.DONE && bus.REG_WE && bus.CMD_READY) trio++;
    end
    bus.DATA_VALID = 0;
    chk("clamp cycles", cyc, 17);
    chk("clamp writes", nwr, 15);
    chk("clamp seen", seen, 16'hFFFE);
    chk("clamp dup", dup, 0);
    chk("clamp done", ndone, 1);
    chk("clamp trio", trio, 0);
    chk("clamp pend end", bus.PENDING, 0);
    @(posedge CLK);
    #1;
    chk("clamp bank r0", bank[0], 0);
    chk("clamp bank r5", bank[5], 32'h5A5A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
